// File: rtl/data_mem_io_pkg.sv
// Shared definitions for the data memory / MMIO block: register addresses
// and the active-low 7-segment glyph table.
package data_mem_io_pkg;

  localparam logic [31:0] MMIO_SW  = 32'h0000_0400;
  localparam logic [31:0] MMIO_LED = 32'h0000_0404;
  localparam logic [31:0] MMIO_HEX = 32'h0000_0408;
  localparam logic [31:0] MMIO_CYC = 32'h0000_040C;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry 15 first.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/data_mem_io_hex7seg.sv
// Combinational hex-digit to active-low 7-segment decoder.
module hex7seg
  import data_mem_io_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/data_mem_io.sv
// Word-addressed data RAM plus memory-mapped switches, LEDs, hex display
// and free-running cycle counter.
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int SCAN_BITS  = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int              AW        = $clog2(RAM_WORDS);
  localparam int              DW        = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [31:0]     RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]          addr_w;
  logic                 is_ram, wr_led, wr_hex, wr_cyc;
  logic [31:0]          ram [RAM_WORDS];

  logic [15:0]          led_q, led_d;
  logic [31:0]          hex_q, hex_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [15:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0]          sw_acc_q, sw_acc_d;
  logic [DW-1:0]        deb_cnt_q [16];
  logic [DW-1:0]        deb_cnt_d [16];

  logic [2:0]           digit;
  logic [3:0]           nibble;

  // Byte offset is masked off so every access is a whole word.
  assign addr_w = addr & 32'hFFFF_FFFC;
  assign is_ram = addr_w < RAM_BYTES;
  assign wr_led = memwrite && (addr_w == MMIO_LED);
  assign wr_hex = memwrite && (addr_w == MMIO_HEX);
  assign wr_cyc = memwrite && (addr_w == MMIO_CYC);

  // NOTE: RAM has no reset branch; its contents must survive reset, and a
  // reset loop over a memory would also block inference of a RAM macro.
  always_ff @(posedge clk) begin
    if (memwrite && is_ram) ram[addr_w[AW+1:2]] <= writedata;
  end

  always_comb begin
    readdata = '0;
    if (is_ram) begin
      readdata = ram[addr_w[AW+1:2]];
    end else begin
      case (addr_w)
        MMIO_SW:  readdata = {16'h0000, sw_acc_q};
        MMIO_LED: readdata = {16'h0000, led_q};
        MMIO_HEX: readdata = hex_q;
        MMIO_CYC: readdata = cyc_q;
        default:  readdata = '0;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default up front so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    led_d    = wr_led ? writedata[15:0] : led_q;
    hex_d    = wr_hex ? writedata : hex_q;
    cyc_d    = wr_cyc ? writedata : cyc_q + 32'd1;
    scan_d   = scan_q + SCAN_BITS'(1);
    sync1_d  = sw;
    sync2_d  = sync1_q;
    sw_acc_d = sw_acc_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 16; i++) begin
      if (sync2_q[i] != sw_acc_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          sw_acc_d[i]  = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      hex_q    <= '0;
      cyc_q    <= '0;
      scan_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sw_acc_q <= '0;
      for (int i = 0; i < 16; i++) deb_cnt_q[i] <= '0;
    end else begin
      led_q     <= led_d;
      hex_q     <= hex_d;
      cyc_q     <= cyc_d;
      scan_q    <= scan_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sw_acc_q  <= sw_acc_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign led    = led_q;
  assign digit  = scan_q[SCAN_BITS-1 -: 3];
  assign an     = ~(8'd1 << digit);
  assign nibble = hex_q[{digit, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nib (nibble),
    .seg (seg)
  );

endmodule

// File: tb/tb_data_mem_io.sv
// Directed self-checking bench for data_mem_io (small scan counter so a
// full display sweep fits in 16 cycles).
module tb_data_mem_io;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  data_mem_io #(
    .RAM_WORDS  (64),
    .SCAN_BITS  (4),
    .DEB_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .sw        (sw),
    .led       (led),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    memwrite  = we;
    addr      = a;
    writedata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw    = '0;
    bus(1'b0, 32'h40C, 32'h0);
    tick();
    tick();
    total++; if (led !== 16'h0)      begin bad++; $display("FAIL reset_led got=%h exp=0000", led); end
    total++; if (an !== 8'hFE)       begin bad++; $display("FAIL reset_an got=%h exp=fe", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_cyc got=%h exp=00000000", readdata); end
    reset = 1'b0;
  endtask

  task automatic test_ram();
    bus(1'b1, 32'h010, 32'h1111_1111);
    tick();
    bus(1'b1, 32'h010, 32'hDEAD_BEEF);
    #1;
    total++; if (readdata !== 32'h1111_1111) begin bad++; $display("FAIL ram_same_cycle got=%h exp=11111111", readdata); end
    tick();
    bus(1'b0, 32'h010, 32'h0);
    #1;
    total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_read_010 got=%h exp=deadbeef", readdata); end
    addr = 32'h013;
    #1;
    total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_read_013 got=%h exp=deadbeef", readdata); end
    bus(1'b1, 32'h0FC, 32'hCAFE_F00D);
    tick();
    bus(1'b1, 32'h100, 32'h1234_5678);
    tick();
    bus(1'b0, 32'h0FC, 32'h0);
    #1;
    total++; if (readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL ram_last_word got=%h exp=cafef00d", readdata); end
    addr = 32'h100;
    #1;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL ram_past_end got=%h exp=00000000", readdata); end
  endtask

  task automatic test_led();
    bus(1'b1, 32'h404, 32'h0001_ABCD);
    #1;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL led_same_cycle got=%h exp=00000000", readdata); end
    tick();
    bus(1'b0, 32'h404, 32'h0);
    #1;
    total++; if (led !== 16'hABCD)         begin bad++; $display("FAIL led_port got=%h exp=abcd", led); end
    total++; if (readdata !== 32'h0000_ABCD) begin bad++; $display("FAIL led_read got=%h exp=0000abcd", readdata); end
  endtask

  task automatic test_ignored_writes();
    bus(1'b1, 32'h400, 32'hFFFF_FFFF);
    tick();
    bus(1'b1, 32'h410, 32'hFFFF_FFFF);
    tick();
    bus(1'b0, 32'h400, 32'h0);
    #1;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL sw_write got=%h exp=00000000", readdata); end
    addr = 32'h410;
    #1;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=00000000", readdata); end
    total++; if (led !== 16'hABCD)   begin bad++; $display("FAIL led_kept got=%h exp=abcd", led); end
  endtask

  task automatic test_cyc();
    logic [31:0] exp_cyc [3];
    exp_cyc = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    bus(1'b1, 32'h40C, 32'hFFFF_FFFE);
    tick();
    bus(1'b0, 32'h40C, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (readdata !== exp_cyc[i]) begin
        bad++; $display("FAIL cyc_step%0d got=%h exp=%h", i, readdata, exp_cyc[i]);
      end
    end
  endtask

  task automatic test_debounce();
    bus(1'b0, 32'h400, 32'h0);
    sw = 16'h0001;
    tick(); tick(); tick();
    sw = 16'h0000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (readdata !== 32'h0) begin bad++; $display("FAIL glitch_cycle%0d got=%h exp=00000000", i, readdata); end
    end
    sw = 16'h0001;
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] exp_sw;
      tick();
      exp_sw = (i >= 6) ? 32'h1 : 32'h0;
      total++;
      if (readdata !== exp_sw) begin bad++; $display("FAIL debounce_cycle%0d got=%h exp=%h", i, readdata, exp_sw); end
    end
  endtask

  task automatic test_hex_scan();
    logic [6:0] exp_seg [8];
    logic [7:0] exp_an;
    int         d;
    exp_seg = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    reset = 1'b1;
    bus(1'b0, 32'h0, 32'h0);
    #1;
    bus(1'b1, 32'h408, 32'h89AB_CDEF);
    reset = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j == 1) bus(1'b0, 32'h408, 32'h0);
      d      = (j % 16) / 2;
      exp_an = ~(8'd1 << d);
      total++; if (an !== exp_an)     begin bad++; $display("FAIL scan_an_c%0d got=%h exp=%h", j, an, exp_an); end
      total++; if (seg !== exp_seg[d]) begin bad++; $display("FAIL scan_seg_c%0d got=%h exp=%h", j, seg, exp_seg[d]); end
    end
    total++; if (readdata !== 32'h89AB_CDEF) begin bad++; $display("FAIL hex_read got=%h exp=89abcdef", readdata); end
  endtask

  task automatic test_reset_mid();
    bus(1'b1, 32'h404, 32'h0000_FFFF);
    tick();
    bus(1'b0, 32'h40C, 32'h0);
    tick(); tick(); tick();
    total++; if (led !== 16'hFFFF) begin bad++; $display("FAIL pre_reset_led got=%h exp=ffff", led); end
    total++; if (an !== 8'hFB)     begin bad++; $display("FAIL pre_reset_an got=%h exp=fb", an); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (led !== 16'h0)      begin bad++; $display("FAIL async_led got=%h exp=0000", led); end
    total++; if (an !== 8'hFE)       begin bad++; $display("FAIL async_an got=%h exp=fe", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL async_seg got=%b exp=1000000", seg); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL async_cyc got=%h exp=00000000", readdata); end
    addr = 32'h010;
    #1;
    total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_retained got=%h exp=deadbeef", readdata); end
    bus(1'b1, 32'h404, 32'h0000_FFFF);
    tick();
    total++; if (led !== 16'h0) begin bad++; $display("FAIL reset_write_led got=%h exp=0000", led); end
    bus(1'b1, 32'h40C, 32'h0000_0005);
    tick();
    bus(1'b0, 32'h40C, 32'h0);
    #1;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_write_cyc got=%h exp=00000000", readdata); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_ignored_writes();
    test_cyc();
    test_debounce();
    test_hex_scan();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
